// File: rtl/reg_read_port_if.sv
// Bundle for the register-file read port: bank view, write strobe, read request, pipeline
// control and the registered read results.
interface reg_read_port_if #(
  parameter int unsigned mem_width  = 32,
  parameter int unsigned mem_depth  = 32,
  parameter int unsigned addr_width = 5
);
  logic [mem_width*mem_depth-1:0] Rin_flat;
  logic                           we;
  logic [addr_width-1:0]          waddr;
  logic [mem_width-1:0]           wdata;
  logic                           req_valid;
  logic [addr_width-1:0]          rs1;
  logic [addr_width-1:0]          rs2;
  logic                           stall;
  logic                           flush;
  logic [mem_width-1:0]           rd1;
  logic [mem_width-1:0]           rd2;
  logic                           rd_valid;
  logic [addr_width-1:0]          rs1_q;
  logic [addr_width-1:0]          rs2_q;

  modport master (
    output Rin_flat, we, waddr, wdata, req_valid, rs1, rs2, stall, flush,
    input  rd1, rd2, rd_valid, rs1_q, rs2_q
  );

  modport slave (
    input  Rin_flat, we, waddr, wdata, req_valid, rs1, rs2, stall, flush,
    output rd1, rd2, rd_valid, rs1_q, rs2_q
  );
endinterface

// File: rtl/reg_read_port.sv
// Registered two-port register-file read stage with same-cycle write bypass, zero register,
// stall (with in-place write refresh) and flush.
module reg_read_port #(
  parameter int unsigned mem_width  = 32,
  parameter int unsigned mem_depth  = 32,
  parameter int unsigned addr_width = 5
) (
  input logic           clk,
  input logic           reset,
  reg_read_port_if.slave bus
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e                state_q;
  logic [mem_width-1:0]  rd1_q, rd2_q;
  logic [addr_width-1:0] rs1_q, rs2_q;
  logic [mem_width-1:0]  rd1_res, rd2_res;
  logic                  upd1, upd2;

  // Address 0 always reads zero; a live write to the same address wins over the bank.
  function automatic logic [mem_width-1:0] resolve(
    input logic [addr_width-1:0]          a,
    input logic                           we,
    input logic [addr_width-1:0]          waddr,
    input logic [mem_width-1:0]           wdata,
    input logic [mem_width*mem_depth-1:0] flat
  );
    if (a == '0) begin
      return '0;
    end else if (we && (waddr == a)) begin
      return wdata;
    end else begin
      return flat[int'(a)*mem_width +: mem_width];
    end
  endfunction

  always_comb begin
    rd1_res = resolve(bus.rs1, bus.we, bus.waddr, bus.wdata, bus.Rin_flat);
    rd2_res = resolve(bus.rs2, bus.we, bus.waddr, bus.wdata, bus.Rin_flat);
    upd1    = (state_q == StFull) && bus.we && (bus.waddr != '0) && (bus.waddr == rs1_q);
    upd2    = (state_q == StFull) && bus.we && (bus.waddr != '0) && (bus.waddr == rs2_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else if (bus.flush) begin
      state_q <= StEmpty;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else if (!bus.stall) begin
      state_q <= bus.req_valid ? StFull : StEmpty;
      rd1_q   <= rd1_res;
      rd2_q   <= rd2_res;
      rs1_q   <= bus.rs1;
      rs2_q   <= bus.rs2;
    end else begin
      // Held entry stays coherent with writes landing in the bank while stalled.
      if (upd1) rd1_q <= bus.wdata;
      if (upd2) rd2_q <= bus.wdata;
    end
  end

  assign bus.rd1      = rd1_q;
  assign bus.rd2      = rd2_q;
  assign bus.rs1_q    = rs1_q;
  assign bus.rs2_q    = rs2_q;
  assign bus.rd_valid = (state_q == StFull);

endmodule

// File: tb/tb_reg_read_port.sv
// Directed and randomized check of reg_read_port against a behavioural register-bank model.
module tb_reg_read_port;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_read_port_if #(.mem_width(W), .mem_depth(D), .addr_width(AW)) bus ();

  reg_read_port #(.mem_width(W), .mem_depth(D), .addr_width(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [W-1:0] regs [D];
  logic [W*D-1:0] flat;
  always_comb begin
    flat = '0;
    for (int i = 0; i < int'(D); i++) flat[i*W +: W] = regs[i];
  end
  assign bus.Rin_flat = flat;

  int total = 0;
  int bad   = 0;

  logic         m_valid;
  logic [W-1:0] m_rd1, m_rd2;
  logic [AW-1:0] m_rs1, m_rs2;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd_valid"}, W'(bus.rd_valid), W'(m_valid));
    chk({tag, ".rd1"}, bus.rd1, m_rd1);
    chk({tag, ".rd2"}, bus.rd2, m_rd2);
    chk({tag, ".rs1_q"}, W'(bus.rs1_q), W'(m_rs1));
    chk({tag, ".rs2_q"}, W'(bus.rs2_q), W'(m_rs2));
  endtask

  function automatic logic [W-1:0] ref_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.we && bus.waddr == a) return bus.wdata;
    return regs[a];
  endfunction

  // Inputs already driven; predict the next edge, take it, commit the bank write, compare.
  task automatic step(input string tag);
    logic [W-1:0] n1, n2;
    n1 = ref_read(bus.rs1);
    n2 = ref_read(bus.rs2);
    if (bus.flush) begin
      m_valid = 0; m_rd1 = 0; m_rd2 = 0; m_rs1 = 0; m_rs2 = 0;
    end else if (!bus.stall) begin
      m_valid = bus.req_valid; m_rd1 = n1; m_rd2 = n2; m_rs1 = bus.rs1; m_rs2 = bus.rs2;
    end else if (m_valid && bus.we && bus.waddr != 0) begin
      if (bus.waddr == m_rs1) m_rd1 = bus.wdata;
      if (bus.waddr == m_rs2) m_rd2 = bus.wdata;
    end
    @(posedge clk);
    if (bus.we && bus.waddr != 0) regs[bus.waddr] = bus.wdata;
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic rv, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic st, input logic fl, input logic w,
                       input logic [AW-1:0] wa, input logic [W-1:0] wd);
    bus.req_valid = rv; bus.rs1 = a1; bus.rs2 = a2;
    bus.stall = st; bus.flush = fl; bus.we = w; bus.waddr = wa; bus.wdata = wd;
  endtask

  initial begin
    for (int i = 0; i < int'(D); i++) regs[i] = $urandom;
    regs[0] = 32'hA5A5_5A5A;  // bank garbage at index 0 must never leak out
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    m_valid = 0; m_rd1 = 0; m_rd2 = 0; m_rs1 = 0; m_rs2 = 0;
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_edge");
    reset = 1'b1;

    // Plain read.
    regs[3] = 32'hDEAD_BEEF;
    drive(1, 3, 0, 0, 0, 0, 0, 0);
    step("plain");
    chk("plain.rd1_const", bus.rd1, 32'hDEAD_BEEF);

    // Write bypass.
    regs[5] = 32'h11;
    drive(1, 5, 5, 0, 0, 1, 5, 32'h22);
    step("bypass");
    chk("bypass.rd1_const", bus.rd1, 32'h22);

    // Zero protection.
    drive(1, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF);
    step("zero");

    // Stall update on held rs2_q.
    regs[7] = 32'h5;
    drive(1, 2, 7, 0, 0, 0, 0, 0);
    step("stall_fill");
    drive(1, 9, 10, 1, 0, 1, 7, 32'h9);
    step("stall_upd");
    chk("stall_upd.rd2_const", bus.rd2, 32'h9);
    drive(1, 11, 12, 1, 0, 1, 4, 32'h77);
    step("stall_hold");

    // Flush beats stall and a new request.
    drive(1, 3, 5, 1, 1, 0, 0, 0);
    step("flush");

    // Async reset mid-cycle while FULL and stalled.
    drive(1, 3, 7, 0, 0, 0, 0, 0);
    step("pre_reset");
    drive(1, 4, 6, 1, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    m_valid = 0; m_rd1 = 0; m_rd2 = 0; m_rs1 = 0; m_rs2 = 0;
    check_all("async_reset");
    #2 reset = 1'b1;
    drive(1, 3, 3, 0, 0, 0, 0, 0);
    step("post_reset");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] a1, a2, wa;
      a1 = AW'($urandom_range(0, D - 1));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom_range(0, D - 1));
      wa = ($urandom_range(0, 2) == 0) ? a1 : AW'($urandom_range(0, D - 1));
      if (m_valid && $urandom_range(0, 2) == 0) wa = m_rs2;
      drive(1'($urandom_range(0, 3) != 0), a1, a2, 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), wa, $urandom);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_read_port.md
REG_READ_PORT -- requirements
Module: reg_read_port

Interface
REQ-001 SHALL have parameter mem_width, default 32, meaning the width of one register in bits.
REQ-002 SHALL have parameter mem_depth, default 32, meaning the number of registers; mem_depth SHALL be a power of two, at least 2.
REQ-003 SHALL have parameter addr_width, default 5, meaning the register address width; it SHALL equal log2(mem_depth).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port Rin_flat, input, mem_width*mem_depth bits: the register bank contents; register i occupies bits [(i+1)*mem_width-1 : i*mem_width].
REQ-007 SHALL have port we, input, 1 bit: the bank write strobe for this cycle.
REQ-008 SHALL have port waddr, input, addr_width bits: the register index being written.
REQ-009 SHALL have port wdata, input, mem_width bits: the data being written.
REQ-010 SHALL have port req_valid, input, 1 bit: a read request is present.
REQ-011 SHALL have ports rs1 and rs2, input, addr_width bits each: the two read addresses.
REQ-012 SHALL have port stall, input, 1 bit: hold the output stage.
REQ-013 SHALL have port flush, input, 1 bit: invalidate the output stage.
REQ-014 SHALL have ports rd1 and rd2, output, mem_width bits each: the registered read data.
REQ-015 SHALL have port rd_valid, output, 1 bit: rd1 and rd2 are valid.
REQ-016 SHALL have ports rs1_q and rs2_q, output, addr_width bits each: the registered addresses that belong to rd1 and rd2.

Function
REQ-017 SHALL register the read result, giving 1-cycle latency: a request accepted at edge N SHALL present its data after edge N.
REQ-018 SHALL accept a request on an edge where stall=0 and flush=0; on acceptance, rd_valid SHALL become req_valid, rs1_q/rs2_q SHALL load rs1/rs2, and rd1/rd2 SHALL load the resolved read values.
REQ-019 SHALL resolve each read value in priority order: address 0 gives all-zero; otherwise, if we=1 and waddr equals the address and waddr!=0, the value is wdata (write bypass); otherwise it is the addressed slice of Rin_flat.
REQ-020 SHALL keep register 0 at zero at all times, including while a write to address 0 is active.
REQ-021 SHALL hold rd_valid, rs1_q and rs2_q on any edge where stall=1 and flush=0.
REQ-022 SHALL, while stalled, update rdX on an edge where rd_valid=1, we=1, waddr=rsX_q and waddr!=0, loading wdata; otherwise rdX SHALL hold.
REQ-023 SHALL clear rd_valid on any edge where flush=1; flush SHALL take priority over stall and over a new request. rd1, rd2, rs1_q and rs2_q SHALL be cleared to 0 on flush.
REQ-024 SHALL treat rs1=rs2 as two independent reads that give identical data.
REQ-025 SHALL have only two control states: EMPTY (rd_valid=0) and FULL (rd_valid=1). Transitions: EMPTY->FULL on accept with req_valid=1; FULL->EMPTY on flush, or on accept with req_valid=0; otherwise the state holds.
REQ-026 SHALL use no combinational path from any input to any output.

Reset
REQ-027 SHALL, while reset=0, asynchronously force rd_valid=0, rd1=0, rd2=0, rs1_q=0 and rs2_q=0, independent of clk.
REQ-028 SHALL resume normal operation on the first rising edge after reset returns to 1; a reset during a stall SHALL discard the held data.

Verification
REQ-029 SHALL pass plain read: register 3 = 0xDEADBEEF, request rs1=3, rs2=0, stall=0 -> next cycle rd1=0xDEADBEEF, rd2=0, rd_valid=1, rs1_q=3.
REQ-030 SHALL pass bypass: register 5 = 0x11, same cycle we=1, waddr=5, wdata=0x22, request rs1=5 -> rd1=0x22.
REQ-031 SHALL pass zero protection: we=1, waddr=0, wdata=0xFFFFFFFF, request rs1=0, rs2=0 -> rd1=0, rd2=0.
REQ-032 SHALL pass stall update: FULL with rs2_q=7 and rd2=0x5, then stall=1 with a write to register 7 of 0x9 -> rd2=0x9, rd_valid=1, while new request inputs are ignored.
REQ-033 SHALL pass flush priority: flush=1, stall=1, req_valid=1 on the same edge -> rd_valid=0, rd1=0, rd2=0.
REQ-034 SHALL pass async reset: reset driven low mid-cycle while FULL -> rd_valid=0 and all outputs 0 before the next clk edge.
